// File: rtl/eth_gen_pkg.sv
// Shared MII code constants, interrupt codes and scheduler state type
// for the eth_1600g frame generator datapath.
package eth_gen_pkg;

    localparam logic [7:0] IDLE_CODE     = 8'h07;
    localparam logic [7:0] START_CODE    = 8'hFB;
    localparam logic [7:0] PREAMBLE_CODE = 8'h55;
    localparam logic [7:0] SFD_CODE      = 8'hD5;
    localparam logic [7:0] TERM_CODE     = 8'hFD;

    localparam logic [7:0] STOP_TX   = 8'h01;
    localparam logic [7:0] STOP_DATA = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_EOF,
        S_GAP
    } sched_state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_frame_scheduler_if.sv
// Request/grant and generator-side signal bundle of the frame scheduler.
// master = scheduler side, slave = sources plus generator side.
interface eth_frame_scheduler_if #(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]   i_req;
    logic [NUM_REQ*8-1:0] i_interrupt;
    logic [7:0]           i_gen_tx_data;
    logic [NUM_REQ-1:0]   o_grant;
    logic [NUM_REQ-1:0]   o_done;
    logic                 o_timeout;
    logic                 o_busy;
    logic                 o_gen_start;
    logic [7:0]           o_gen_interrupt;

    modport master (
        input  i_req,
        input  i_interrupt,
        input  i_gen_tx_data,
        output o_grant,
        output o_done,
        output o_timeout,
        output o_busy,
        output o_gen_start,
        output o_gen_interrupt
    );

    modport slave (
        output i_req,
        output i_interrupt,
        output i_gen_tx_data,
        input  o_grant,
        input  o_done,
        input  o_timeout,
        input  o_busy,
        input  o_gen_start,
        input  o_gen_interrupt
    );

endinterface

// File: rtl/eth_frame_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping at N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(ptr) + i) % N);
            if (!valid && req[j]) begin
                valid    = 1'b1;
                idx      = j;
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_frame_scheduler.sv
// Round-robin scheduler sharing one MII frame generator between
// NUM_REQ sources, with end-of-frame watch, watchdog and inter-frame gap.
module eth_frame_scheduler
    import eth_gen_pkg::*;
#(
    parameter int         NUM_REQ        = 4,
    parameter int         IFG_CYCLES     = 12,
    parameter int         TIMEOUT_CYCLES = 128,
    parameter logic [7:0] TERMINATE_CODE = TERM_CODE
) (
    input logic                   clk,
    input logic                   i_rst_n,
    eth_frame_scheduler_if.master bus
);

    localparam int IW   = clog2_min1(NUM_REQ);
    localparam int CMAX = (TIMEOUT_CYCLES > IFG_CYCLES) ?
                          TIMEOUT_CYCLES : IFG_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] IFG_LAST =
        CW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    sched_state_t       state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] oh_q, oh_d;
    logic [7:0]         int_q, int_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               busy_q, busy_d;
    logic               start_q, start_d;
    logic [7:0]         gint_q, gint_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic [7:0]         sel_int;
    logic               term;
    logic [IW-1:0]      ptr_next;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req   (bus.i_req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign sel_int  = bus.i_interrupt[{arb_idx, 3'b000} +: 8];
    assign term     = (bus.i_gen_tx_data == TERMINATE_CODE);
    assign ptr_next = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        oh_d    = oh_q;
        int_d   = int_q;
        grant_d = '0;
        done_d  = '0;
        tmo_d   = 1'b0;
        start_d = 1'b0;
        gint_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    state_d = S_START;
                    idx_d   = arb_idx;
                    oh_d    = arb_grant;
                    int_d   = sel_int;
                end
            end
            S_START: begin
                start_d = 1'b1;
                grant_d = oh_q;
                gint_d  = int_q;
                cnt_d   = '0;
                state_d = S_WAIT_EOF;
            end
            S_WAIT_EOF: begin
                cnt_d = cnt_q + 1'b1;
                // terminate takes priority over a coincident watchdog expiry
                if (term || cnt_q == TMO_LAST) begin
                    done_d  = oh_q;
                    tmo_d   = !term;
                    cnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = (IFG_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    grant_d = oh_q;
                    gint_d  = int_q;
                end
            end
            S_GAP: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            oh_q    <= '0;
            int_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            gint_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            oh_q    <= oh_d;
            int_q   <= int_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            gint_q  <= gint_d;
        end
    end

    assign bus.o_grant         = grant_q;
    assign bus.o_done          = done_q;
    assign bus.o_timeout       = tmo_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_gen_start     = start_q;
    assign bus.o_gen_interrupt = gint_q;

endmodule

// File: tb/tb_eth_frame_scheduler.sv
// Self-checking bench for eth_frame_scheduler: directed vector table,
// reset/priority sequences and randomized frames against a frame-level model.
module tb_eth_frame_scheduler;

    localparam int         N     = 4;
    localparam int         IFG   = 12;
    localparam int         TMO   = 128;
    localparam logic [7:0] TERM  = 8'hFD;
    localparam logic [7:0] IDLEC = 8'h07;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    eth_frame_scheduler_if #(.NUM_REQ(N)) bus ();

    eth_frame_scheduler #(
        .NUM_REQ        (N),
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO),
        .TERMINATE_CODE (TERM)
    ) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] intr;
        int          len;
        logic [3:0]  req_mid;
        int          lat;
        logic [3:0]  g;
        logic [7:0]  gi;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // waits (bounded) for o_gen_start, checking o_busy on the way
    task automatic wait_start(input bit from_done, input int exp_lat,
                              input string nm);
        int k = 0;
        forever begin
            chk({nm, "_busy"}, 32'(bus.o_busy),
                32'(from_done ? (k != IFG) : (k != 0)));
            if (bus.o_gen_start) break;
            if (k >= 300) break;
            @(negedge clk);
            k++;
        end
        chk({nm, "_lat"}, k, exp_lat);
    endtask

    // called on the start-pulse cycle; plays the generator for one frame
    task automatic run_frame(input int len, input logic [3:0] g,
                             input logic [7:0] gi, input logic [3:0] req_mid,
                             input logic [31:0] intr_mid);
        bit tmo;
        int off;
        tmo = (len >= TMO);
        off = tmo ? TMO : len + 1;
        for (int j = 0; j <= off; j++) begin
            chk("start", 32'(bus.o_gen_start), 32'(j == 0));
            chk("grant", 32'(bus.o_grant), 32'((j < off) ? g : 4'b0));
            chk("gen_int", 32'(bus.o_gen_interrupt),
                32'((j < off) ? gi : 8'h00));
            chk("done", 32'(bus.o_done), 32'((j == off) ? g : 4'b0));
            chk("timeout", 32'(bus.o_timeout), 32'((j == off) && tmo));
            chk("busy_frame", 32'(bus.o_busy), 32'd1);
            bus.i_gen_tx_data = (j == len) ? TERM : IDLEC;
            if (j == 1) bus.i_interrupt = intr_mid;
            if (j == 2) bus.i_req = req_mid;
            if (j < off) @(negedge clk);
        end
        bus.i_gen_tx_data = IDLEC;
        bus.i_req         = req_mid;
        bus.i_interrupt   = intr_mid;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    initial begin
        int          ptr;
        int          pick;
        int          len;
        logic [3:0]  cur_req;
        logic [3:0]  mid;
        logic [31:0] cur_intr;
        logic [31:0] im;

        total = 0;
        bad   = 0;
        tbl[0] = '{4'b0001, 32'h0000_0002, 60,  4'b0001, 2,  4'b0001, 8'h02};
        tbl[1] = '{4'b1111, 32'h4433_2211, 10,  4'b1111, 14, 4'b0010, 8'h22};
        tbl[2] = '{4'b1111, 32'h4433_2211, 200, 4'b1111, 14, 4'b0100, 8'h33};
        tbl[3] = '{4'b1111, 32'h4433_2211, 127, 4'b1111, 14, 4'b1000, 8'h44};
        tbl[4] = '{4'b1111, 32'h4433_2211, 0,   4'b1111, 14, 4'b0001, 8'h11};
        tbl[5] = '{4'b0100, 32'hA0B0_C0D0, 5,   4'b0100, 14, 4'b0100, 8'hB0};
        tbl[6] = '{4'b0011, 32'hA0B0_C0D0, 30,  4'b0011, 14, 4'b0001, 8'hD0};
        tbl[7] = '{4'b0100, 32'h0002_0101, 20,  4'b0010, 14, 4'b0100, 8'h02};
        tbl[8] = '{4'b0010, 32'h0002_0101, 40,  4'b0010, 14, 4'b0010, 8'h01};

        bus.i_req         = '0;
        bus.i_interrupt   = '0;
        bus.i_gen_tx_data = IDLEC;
        rst_n             = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.o_grant), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_timeout", 32'(bus.o_timeout), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_start", 32'(bus.o_gen_start), 32'd0);
        chk("rst_gen_int", 32'(bus.o_gen_interrupt), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(bus.o_busy), 32'd0);

        for (int r = 0; r < 9; r++) begin
            bus.i_req       = tbl[r].req;
            bus.i_interrupt = tbl[r].intr;
            wait_start(r != 0, tbl[r].lat, "row");
            run_frame(tbl[r].len, tbl[r].g, tbl[r].gi, tbl[r].req_mid,
                      $urandom);
        end

        // reset mid-frame; pointer must restart at source 0
        bus.i_req       = 4'b0110;
        bus.i_interrupt = 32'h1122_3344;
        wait_start(1, 14, "pre_rst");
        chk("pre_rst_grant", 32'(bus.o_grant), 32'h4);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(bus.o_grant), 32'd0);
        chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        chk("mid_rst_gen_int", 32'(bus.o_gen_interrupt), 32'd0);
        chk("mid_rst_start", 32'(bus.o_gen_start), 32'd0);
        bus.i_req = 4'b0111;
        @(negedge clk);
        rst_n = 1'b1;
        wait_start(0, 2, "post_rst");
        im = $urandom;
        run_frame(15, 4'b0001, 8'h44, 4'b0110, im);

        ptr      = 1;
        cur_req  = 4'b0110;
        cur_intr = im;
        for (int f = 0; f < 30; f++) begin
            cur_req = cur_req | (4'($urandom) & 4'($urandom));
            if (cur_req == 4'b0) cur_req = 4'b1 << $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) cur_intr = $urandom;
            bus.i_req       = cur_req;
            bus.i_interrupt = cur_intr;
            pick = rr_pick(cur_req, ptr);
            wait_start(1, 14, "rnd");
            len = ($urandom_range(0, 9) == 0) ? TMO - 1
                                              : int'($urandom_range(0, 150));
            mid = cur_req & 4'($urandom);
            im  = $urandom;
            run_frame(len, 4'(1 << pick), cur_intr[8*pick +: 8], mid, im);
            cur_req  = mid;
            cur_intr = im;
            ptr      = (pick + 1) % N;
            if (cur_req[pick] && $urandom_range(0, 1) == 1)
                cur_req[pick] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
